// File: rtl/io_load_controller.sv
// Sequences the wide input shift register: accepts a beat stream, drives shift_en/shift_data,
// optionally zero-pads short frames, then offers the filled register with a valid/ready handshake.
module io_load_controller #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 256,
  localparam int FACTOR = REG_W / DATA_W,
  localparam int CNT_W  = $clog2(FACTOR + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  cfg_words,
  input  logic              cfg_pad_en,
  output logic              shift_en,
  output logic [DATA_W-1:0] shift_data,
  output logic              reg_valid,
  input  logic              reg_ready,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic              busy
);

  localparam logic [CNT_W-1:0] FACTOR_C = CNT_W'(FACTOR);

  typedef enum logic [1:0] {IDLE, FILL, PAD, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] words_reg, words_next;
  logic             pad_en_reg, pad_en_next;
  logic             reg_valid_reg, reg_valid_next;
  logic [CNT_W-1:0] cfg_eff;
  logic [CNT_W-1:0] cnt_inc;

  // Out-of-range frame lengths fall back to a full frame.
  assign cfg_eff = (cfg_words == '0 || cfg_words > FACTOR_C) ? FACTOR_C : cfg_words;
  assign cnt_inc = cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      words_reg     <= '0;
      pad_en_reg    <= 1'b0;
      reg_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      words_reg     <= words_next;
      pad_en_reg    <= pad_en_next;
      reg_valid_reg <= reg_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    words_next     = words_reg;
    pad_en_next    = pad_en_reg;
    reg_valid_next = reg_valid_reg;
    in_ready       = 1'b0;
    shift_en       = 1'b0;
    shift_data     = '0;
    case (state_reg)
      IDLE: begin
        in_ready   = 1'b1;
        shift_en   = in_valid;
        shift_data = in_data;
        if (in_valid) begin
          words_next  = cfg_eff;
          pad_en_next = cfg_pad_en;
          cnt_next    = CNT_W'(1);
          if (cfg_eff == CNT_W'(1)) begin
            if (cfg_pad_en && (FACTOR > 1)) begin
              state_next = PAD;
            end else begin
              state_next     = HOLD;
              reg_valid_next = 1'b1;
            end
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        in_ready   = 1'b1;
        shift_en   = in_valid;
        shift_data = in_data;
        if (in_valid) begin
          cnt_next = cnt_inc;
          if (cnt_inc == words_reg) begin
            if (pad_en_reg && (words_reg < FACTOR_C)) begin
              state_next = PAD;
            end else begin
              state_next     = HOLD;
              reg_valid_next = 1'b1;
            end
          end
        end
      end
      PAD: begin
        // Zero shifts push the first data beat up into the top slot.
        shift_en = 1'b1;
        cnt_next = cnt_inc;
        if (cnt_inc == FACTOR_C) begin
          state_next     = HOLD;
          reg_valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (reg_ready) begin
          state_next     = IDLE;
          cnt_next       = '0;
          reg_valid_next = 1'b0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign reg_valid = reg_valid_reg;
  assign beat_cnt  = cnt_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_io_load_controller.sv
// Bench for io_load_controller with DATA_W=8, REG_W=32: directed vector table, hand-written
// hold/reset sequences, and a randomized run against a frame-level reference model.
module tb_io_load_controller;

  localparam int DATA_W = 8;
  localparam int REG_W  = 32;
  localparam int FACTOR = REG_W / DATA_W;
  localparam int CNT_W  = $clog2(FACTOR + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [CNT_W-1:0]  cfg_words;
  logic              cfg_pad_en;
  logic              shift_en;
  logic [DATA_W-1:0] shift_data;
  logic              reg_valid;
  logic              reg_ready;
  logic [CNT_W-1:0]  beat_cnt;
  logic              busy;

  int checks = 0;
  int errors = 0;

  io_load_controller #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_words(cfg_words), .cfg_pad_en(cfg_pad_en), .shift_en(shift_en),
    .shift_data(shift_data), .reg_valid(reg_valid), .reg_ready(reg_ready),
    .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the io shift register the controller feeds.
  logic [REG_W-1:0] sreg = '0;
  always @(posedge clk) if (shift_en) sreg <= {sreg[REG_W-DATA_W-1:0], shift_data};

  typedef struct {
    logic v; logic [7:0] d; logic [2:0] w; logic p; logic rr;
    logic e_ir; logic e_se; logic [7:0] e_sd; logic e_rv; logic [2:0] e_bc;
    logic chk_sreg; logic [31:0] e_sreg;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] w,
                       input logic p, input logic rr);
    in_valid = v; in_data = d; cfg_words = w; cfg_pad_en = p; reg_ready = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic [2:0] w, input logic p,
                     input logic rr, input logic ir, input logic se, input logic [7:0] sd,
                     input logic rv, input logic [2:0] bc, input logic cs, input logic [31:0] sr);
    vecs.push_back('{v, d, w, p, rr, ir, se, sd, rv, bc, cs, sr});
  endtask

  function automatic int eff_words(input int w);
    return (w == 0 || w > FACTOR) ? FACTOR : w;
  endfunction

  // Frame-level reference model state
  int          m_shifts = 0, m_acc = 0, m_words = 0, m_frames = 0;
  bit          m_pad = 0;
  logic [7:0]  m_beats[$];

  initial begin
    drive(0, 8'h00, 3'd4, 0, 0);
    rst = 1'b0;
    tick(); tick();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_shift_en", 32'(shift_en), 32'd0);
    chk("reset_reg_valid", 32'(reg_valid), 32'd0);
    chk("reset_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    tick();

    // Full frame, padded short frame, unpadded short frame, bubbly full frame (cfg 7 and 0).
    add(1,8'h11,4,0,0, 1,1,8'h11,0,0, 0,0);
    add(1,8'h22,4,0,0, 1,1,8'h22,0,1, 0,0);
    add(1,8'h33,4,0,0, 1,1,8'h33,0,2, 0,0);
    add(1,8'h44,4,0,0, 1,1,8'h44,0,3, 0,0);
    add(1,8'h55,4,0,0, 0,0,8'h00,1,4, 1,32'h11223344);
    add(1,8'h55,4,0,1, 0,0,8'h00,1,4, 1,32'h11223344);
    add(1,8'hAA,2,1,0, 1,1,8'hAA,0,0, 0,0);
    add(1,8'hBB,4,0,0, 1,1,8'hBB,0,1, 0,0);
    add(1,8'hCC,4,0,0, 0,1,8'h00,0,2, 0,0);
    add(1,8'hCC,4,0,0, 0,1,8'h00,0,3, 0,0);
    add(1,8'hCC,4,0,1, 0,0,8'h00,1,4, 1,32'hAABB0000);
    add(0,8'h00,2,0,0, 1,0,8'h00,0,0, 0,0);
    add(1,8'hAA,2,0,0, 1,1,8'hAA,0,0, 0,0);
    add(1,8'hBB,2,0,0, 1,1,8'hBB,0,1, 0,0);
    add(0,8'h00,2,0,1, 0,0,8'h00,1,2, 1,32'h0000AABB);
    add(0,8'h00,0,0,0, 1,0,8'h00,0,0, 0,0);
    add(1,8'h01,7,0,0, 1,1,8'h01,0,0, 0,0);
    add(0,8'h00,7,0,0, 1,0,8'h00,0,1, 0,0);
    add(1,8'h02,0,0,0, 1,1,8'h02,0,1, 0,0);
    add(0,8'h00,0,0,0, 1,0,8'h00,0,2, 0,0);
    add(1,8'h03,0,0,0, 1,1,8'h03,0,2, 0,0);
    add(0,8'h00,0,0,0, 1,0,8'h00,0,3, 0,0);
    add(1,8'h04,0,0,0, 1,1,8'h04,0,3, 0,0);
    add(0,8'h00,0,0,1, 0,0,8'h00,1,4, 1,32'h01020304);
    add(0,8'h00,0,1,0, 1,0,8'h00,0,0, 0,0);
    add(1,8'h9C,0,1,0, 1,1,8'h9C,0,0, 0,0);
    add(1,8'h9D,1,1,0, 1,1,8'h9D,0,1, 0,0);
    add(1,8'h9E,1,1,0, 1,1,8'h9E,0,2, 0,0);
    add(1,8'h9F,1,1,0, 1,1,8'h9F,0,3, 0,0);
    add(0,8'h00,1,1,1, 0,0,8'h00,1,4, 1,32'h9C9D9E9F);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].w, vecs[i].p, vecs[i].rr);
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_shift_en", i), 32'(shift_en), 32'(vecs[i].e_se));
      if (vecs[i].e_se)
        chk($sformatf("vec%0d_shift_data", i), 32'(shift_data), 32'(vecs[i].e_sd));
      chk($sformatf("vec%0d_reg_valid", i), 32'(reg_valid), 32'(vecs[i].e_rv));
      chk($sformatf("vec%0d_beat_cnt", i), 32'(beat_cnt), 32'(vecs[i].e_bc));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_bc != 0));
      if (vecs[i].chk_sreg)
        chk($sformatf("vec%0d_reg_data", i), sreg, vecs[i].e_sreg);
      $display("vec %0d: v=%0d d=%h rdy=%0d sh=%0d rv=%0d cnt=%0d", i, vecs[i].v, vecs[i].d,
               in_ready, shift_en, reg_valid, beat_cnt);
      tick();
    end

    // Consumer stalls for 5 cycles while the source keeps offering a beat.
    for (int i = 0; i < FACTOR; i++) begin
      drive(1, 8'hA1 + 8'(i), 3'd4, 0, 0);
      #1;
      chk("stall_fill_shift_en", 32'(shift_en), 32'd1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'hEE, 3'd4, 0, 0);
      #1;
      chk("stall_reg_valid", 32'(reg_valid), 32'd1);
      chk("stall_shift_en", 32'(shift_en), 32'd0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_reg_data", sreg, 32'hA1A2A3A4);
      tick();
    end
    drive(1, 8'h5A, 3'd4, 0, 1);
    #1;
    chk("handshake_same_cycle_ready", 32'(in_ready), 32'd0);
    chk("handshake_same_cycle_shift", 32'(shift_en), 32'd0);
    tick();
    drive(1, 8'h5A, 3'd4, 0, 0);
    #1;
    chk("after_handshake_ready", 32'(in_ready), 32'd1);
    chk("after_handshake_shift", 32'(shift_en), 32'd1);
    chk("after_handshake_cnt", 32'(beat_cnt), 32'd0);
    tick();
    drive(1, 8'h5B, 3'd4, 0, 0);
    tick();
    chk("pre_reset_cnt", 32'(beat_cnt), 32'd2);
    $display("frame stall: accepted 2 beats of next frame before reset");

    // Asynchronous abort mid-frame.
    drive(0, 8'h00, 3'd4, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("abort_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("abort_reg_valid", 32'(reg_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    tick();
    chk("abort_no_valid", 32'(reg_valid), 32'd0);
    rst = 1'b1;
    tick();

    // Randomized traffic against the frame-level model.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int  target;
      bit  hold, e_ready, padding, e_se;
      logic [31:0] packed_v, exp_v, mask;
      drive(($urandom_range(0, 9) < 7), 8'($urandom), 3'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom));
      #1;
      target  = m_pad ? FACTOR : m_words;
      hold    = (m_shifts > 0) && (m_shifts == target);
      e_ready = !((m_shifts > 0) && (m_acc == m_words));
      padding = (m_shifts > 0) && (m_acc == m_words) && (m_shifts < target);
      e_se    = (e_ready && in_valid) || padding;
      chk("rnd_in_ready", 32'(in_ready), 32'(e_ready));
      chk("rnd_shift_en", 32'(shift_en), 32'(e_se));
      if (e_se) chk("rnd_shift_data", 32'(shift_data), padding ? 32'd0 : 32'(in_data));
      chk("rnd_reg_valid", 32'(reg_valid), 32'(hold));
      chk("rnd_beat_cnt", 32'(beat_cnt), 32'(m_shifts));
      chk("rnd_busy", 32'(busy), 32'(m_shifts > 0));
      if (hold) begin
        packed_v = '0;
        foreach (m_beats[k]) packed_v = (packed_v << DATA_W) | 32'(m_beats[k]);
        if (m_pad) begin
          exp_v = packed_v << (DATA_W * (FACTOR - m_words));
          chk("rnd_reg_data", sreg, exp_v);
        end else begin
          mask = (m_words == FACTOR) ? 32'hFFFF_FFFF : ((32'd1 << (DATA_W * m_words)) - 1);
          chk("rnd_reg_data", sreg & mask, packed_v);
        end
        if (reg_ready) begin
          m_frames++;
          $display("frame %0d: words=%0d pad=%0d data=%h", m_frames, m_words, m_pad, sreg);
          m_shifts = 0; m_acc = 0; m_beats.delete();
        end
      end else if (e_se) begin
        if (m_shifts == 0) begin
          m_words = eff_words(int'(cfg_words));
          m_pad   = cfg_pad_en;
        end
        m_shifts++;
        if (!padding) begin
          m_acc++;
          m_beats.push_back(in_data);
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
